// File: rtl/ili934x_fill_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ili934x_fill_sequencer
// Description : Host-side scheduler for the ILI934x 8080 driver. Kicks panel
//               init after reset, then turns rectangle-fill requests into a
//               window set, a stream start, a raster-order pixel stream
//               (solid or checker) and a drain wait.
// Revision    : 1.0 - initial release
// ============================================================================
module ili934x_fill_sequencer #(
    parameter int X_RES            = 240,
    parameter int Y_RES            = 320,
    parameter int AUTO_INIT        = 1,
    parameter int INIT_TIMEOUT_CYC = 50_000_000,
    parameter int CELL_LOG2        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_x0,
    input  logic [15:0] req_y0,
    input  logic [15:0] req_x1,
    input  logic [15:0] req_y1,
    input  logic        req_mode,
    input  logic [15:0] req_color0,
    input  logic [15:0] req_color1,
    output logic        panel_ready,
    output logic        done_stb,
    output logic        err_stb,
    output logic        drv_init_start,
    input  logic        drv_init_done,
    output logic        drv_win_set_stb,
    output logic [15:0] drv_win_x0,
    output logic [15:0] drv_win_y0,
    output logic [15:0] drv_win_x1,
    output logic [15:0] drv_win_y1,
    output logic        drv_stream_start,
    output logic [15:0] drv_pix_data,
    output logic        drv_pix_valid,
    input  logic        drv_pix_ready,
    input  logic        drv_busy
);

    localparam logic [2:0] S_INIT_KICK = 3'd0;
    localparam logic [2:0] S_WAIT_INIT = 3'd1;
    localparam logic [2:0] S_READY     = 3'd2;
    localparam logic [2:0] S_WIN       = 3'd3;
    localparam logic [2:0] S_START     = 3'd4;
    localparam logic [2:0] S_STREAM    = 3'd5;
    localparam logic [2:0] S_DRAIN     = 3'd6;

    localparam logic [15:0] c_X_RES     = 16'(X_RES);
    localparam logic [15:0] c_Y_RES     = 16'(Y_RES);
    localparam logic        c_TO_EN     = (INIT_TIMEOUT_CYC != 0);
    localparam logic [31:0] c_TO_LAST   = (INIT_TIMEOUT_CYC == 0) ? 32'd0 : 32'(INIT_TIMEOUT_CYC - 1);
    // Busy from the driver lags the last pixel by this many cycles
    localparam logic [1:0]  c_DRAIN_IGN = 2'd2;

    // State and counters
    logic [2:0]  r_state, w_state_nxt;
    logic [31:0] r_to_cnt, w_to_cnt_nxt;
    logic [1:0]  r_drain_cnt, w_drain_cnt_nxt;
    logic [15:0] r_x, w_x_nxt;
    logic [15:0] r_y, w_y_nxt;

    // Latched request
    logic [15:0] r_win_x0, r_win_y0, r_win_x1, r_win_y1;
    logic        r_mode;
    logic [15:0] r_color0, r_color1;
    logic        w_latch;

    // Registered outputs and their next values
    logic        r_req_ready,    w_req_ready_nxt;
    logic        r_panel_ready,  w_panel_ready_nxt;
    logic        r_done_stb,     w_done_nxt;
    logic        r_err_stb,      w_err_nxt;
    logic        r_init_start,   w_init_start_nxt;
    logic        r_win_set_stb,  w_win_set_nxt;
    logic        r_stream_start, w_stream_start_nxt;
    logic [15:0] r_pix_data,     w_pix_data_nxt;
    logic        r_pix_valid,    w_pix_valid_nxt;

    logic        w_accept;
    logic        w_req_ok;
    logic        w_xfer;
    logic        w_row_end;
    logic        w_last;
    logic [15:0] w_x_adv;
    logic [15:0] w_y_adv;

    // Colour of pixel (x, y): checker cells are taken relative to the rectangle origin
    function automatic logic [15:0] f_pixel(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] x0,
        input logic [15:0] y0,
        input logic        mode,
        input logic [15:0] c0,
        input logic [15:0] c1
    );
        logic [15:0] dx;
        logic [15:0] dy;
        dx = x - x0;
        dy = y - y0;
        if (mode && (dx[CELL_LOG2] ^ dy[CELL_LOG2]))
            return c1;
        return c0;
    endfunction

    assign w_accept  = (r_state == S_READY) && r_req_ready && req_valid;
    assign w_req_ok  = (req_x1 >= req_x0) && (req_y1 >= req_y0) &&
                       (req_x1 < c_X_RES) && (req_y1 < c_Y_RES);
    assign w_xfer    = r_pix_valid && drv_pix_ready;
    assign w_row_end = (r_x == r_win_x1);
    assign w_last    = w_row_end && (r_y == r_win_y1);
    assign w_x_adv   = w_row_end ? r_win_x0 : (r_x + 16'd1);
    assign w_y_adv   = w_row_end ? (r_y + 16'd1) : r_y;

    // Next-state and next-output decode; outputs are the registered image of these
    always_comb begin
        w_state_nxt        = r_state;
        w_req_ready_nxt    = 1'b0;
        w_panel_ready_nxt  = r_panel_ready;
        w_done_nxt         = 1'b0;
        w_err_nxt          = 1'b0;
        w_init_start_nxt   = 1'b0;
        w_win_set_nxt      = 1'b0;
        w_stream_start_nxt = 1'b0;
        w_pix_valid_nxt    = 1'b0;
        w_pix_data_nxt     = r_pix_data;
        w_to_cnt_nxt       = 32'd0;
        w_drain_cnt_nxt    = 2'd0;
        w_x_nxt            = r_x;
        w_y_nxt            = r_y;
        w_latch            = 1'b0;

        case (r_state)
            S_INIT_KICK: begin
                w_panel_ready_nxt = 1'b0;
                // With manual init the request only triggers init; it stays pending
                if ((AUTO_INIT != 0) || req_valid) begin
                    w_init_start_nxt = 1'b1;
                    w_state_nxt      = S_WAIT_INIT;
                end
            end
            S_WAIT_INIT: begin
                w_panel_ready_nxt = 1'b0;
                if (drv_init_done) begin
                    w_panel_ready_nxt = 1'b1;
                    w_req_ready_nxt   = 1'b1;
                    w_state_nxt       = S_READY;
                end else if (c_TO_EN && (r_to_cnt == c_TO_LAST)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_INIT_KICK;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 32'd1;
                end
            end
            S_READY: begin
                w_req_ready_nxt = 1'b1;
                if (w_accept) begin
                    if (w_req_ok) begin
                        w_latch         = 1'b1;
                        w_req_ready_nxt = 1'b0;
                        w_win_set_nxt   = 1'b1;
                        w_state_nxt     = S_WIN;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_WIN: begin
                w_stream_start_nxt = 1'b1;
                w_x_nxt            = r_win_x0;
                w_y_nxt            = r_win_y0;
                w_state_nxt        = S_START;
            end
            S_START: begin
                w_pix_valid_nxt = 1'b1;
                w_pix_data_nxt  = f_pixel(r_x, r_y, r_win_x0, r_win_y0, r_mode, r_color0, r_color1);
                w_state_nxt     = S_STREAM;
            end
            S_STREAM: begin
                w_pix_valid_nxt = 1'b1;
                if (w_xfer) begin
                    if (w_last) begin
                        w_pix_valid_nxt = 1'b0;
                        w_state_nxt     = S_DRAIN;
                    end else begin
                        w_x_nxt        = w_x_adv;
                        w_y_nxt        = w_y_adv;
                        w_pix_data_nxt = f_pixel(w_x_adv, w_y_adv, r_win_x0, r_win_y0,
                                                 r_mode, r_color0, r_color1);
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt != c_DRAIN_IGN) begin
                    w_drain_cnt_nxt = r_drain_cnt + 2'd1;
                end else if (!drv_busy) begin
                    w_done_nxt      = 1'b1;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = S_READY;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt;
                end
            end
            default: begin
                w_state_nxt = S_INIT_KICK;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_INIT_KICK;
            r_to_cnt       <= 32'd0;
            r_drain_cnt    <= 2'd0;
            r_x            <= 16'd0;
            r_y            <= 16'd0;
            r_req_ready    <= 1'b0;
            r_panel_ready  <= 1'b0;
            r_done_stb     <= 1'b0;
            r_err_stb      <= 1'b0;
            r_init_start   <= 1'b0;
            r_win_set_stb  <= 1'b0;
            r_stream_start <= 1'b0;
            r_pix_data     <= 16'd0;
            r_pix_valid    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_to_cnt       <= w_to_cnt_nxt;
            r_drain_cnt    <= w_drain_cnt_nxt;
            r_x            <= w_x_nxt;
            r_y            <= w_y_nxt;
            r_req_ready    <= w_req_ready_nxt;
            r_panel_ready  <= w_panel_ready_nxt;
            r_done_stb     <= w_done_nxt;
            r_err_stb      <= w_err_nxt;
            r_init_start   <= w_init_start_nxt;
            r_win_set_stb  <= w_win_set_nxt;
            r_stream_start <= w_stream_start_nxt;
            r_pix_data     <= w_pix_data_nxt;
            r_pix_valid    <= w_pix_valid_nxt;
        end
    end

    // Request latch; window outputs stay put until the next accepted fill
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_x0 <= 16'd0;
            r_win_y0 <= 16'd0;
            r_win_x1 <= 16'd0;
            r_win_y1 <= 16'd0;
            r_mode   <= 1'b0;
            r_color0 <= 16'd0;
            r_color1 <= 16'd0;
        end else if (w_latch) begin
            r_win_x0 <= req_x0;
            r_win_y0 <= req_y0;
            r_win_x1 <= req_x1;
            r_win_y1 <= req_y1;
            r_mode   <= req_mode;
            r_color0 <= req_color0;
            r_color1 <= req_color1;
        end
    end

    assign req_ready        = r_req_ready;
    assign panel_ready      = r_panel_ready;
    assign done_stb         = r_done_stb;
    assign err_stb          = r_err_stb;
    assign drv_init_start   = r_init_start;
    assign drv_win_set_stb  = r_win_set_stb;
    assign drv_win_x0       = r_win_x0;
    assign drv_win_y0       = r_win_y0;
    assign drv_win_x1       = r_win_x1;
    assign drv_win_y1       = r_win_y1;
    assign drv_stream_start = r_stream_start;
    assign drv_pix_data     = r_pix_data;
    assign drv_pix_valid    = r_pix_valid;

endmodule
`default_nettype wire

// File: tb/tb_ili934x_fill_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ili934x_fill_sequencer
// Description : Self-checking bench for ili934x_fill_sequencer with a driver
//               model (init done, random pixel stalls, busy tail) and a
//               raster-order reference model of the expected pixel stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ili934x_fill_sequencer;

    localparam int c_X_RES   = 240;
    localparam int c_Y_RES   = 320;
    localparam int c_TIMEOUT = 100;
    localparam int c_CELL    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
    logic        req_mode = 1'b0;
    logic [15:0] req_color0 = '0, req_color1 = '0;
    logic        panel_ready, done_stb, err_stb, drv_init_start;
    logic        drv_init_done = 1'b0;
    logic        drv_win_set_stb;
    logic [15:0] drv_win_x0, drv_win_y0, drv_win_x1, drv_win_y1;
    logic        drv_stream_start;
    logic [15:0] drv_pix_data;
    logic        drv_pix_valid;
    logic        drv_pix_ready = 1'b0;
    logic        drv_busy = 1'b0;

    always #5 clk = ~clk;

    ili934x_fill_sequencer #(
        .X_RES(c_X_RES), .Y_RES(c_Y_RES), .AUTO_INIT(1),
        .INIT_TIMEOUT_CYC(c_TIMEOUT), .CELL_LOG2(c_CELL)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
        .req_mode(req_mode), .req_color0(req_color0), .req_color1(req_color1),
        .panel_ready(panel_ready), .done_stb(done_stb), .err_stb(err_stb),
        .drv_init_start(drv_init_start), .drv_init_done(drv_init_done),
        .drv_win_set_stb(drv_win_set_stb),
        .drv_win_x0(drv_win_x0), .drv_win_y0(drv_win_y0),
        .drv_win_x1(drv_win_x1), .drv_win_y1(drv_win_y1),
        .drv_stream_start(drv_stream_start),
        .drv_pix_data(drv_pix_data), .drv_pix_valid(drv_pix_valid),
        .drv_pix_ready(drv_pix_ready), .drv_busy(drv_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Driver model / event recorder state
    int          cyc = 0;
    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    int          n_init = 0, n_win = 0, n_start = 0, n_done = 0, n_errstb = 0;
    int          init_cyc = 0, win_cyc = 0, start_cyc = 0, done_cyc = 0, err_cyc = 0;
    int          first_xfer_cyc = 0, last_xfer_cyc = 0;
    logic [15:0] wx0 = '0, wy0 = '0, wx1 = '0, wy1 = '0;
    logic        done_busy = 1'b0;
    logic        done_win_ok = 1'b0;
    int          hold_viol = 0;
    int          stall_pct = 0, busy_tail = 0, busy_cnt = 0;
    logic        init_en = 1'b1;
    int          init_timer = 0;
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1;
    logic [15:0] prev_data = '0;

    // Driver side: answers on the falling edge, records every DUT event
    always @(negedge clk) begin
        logic old_busy;
        old_busy = drv_busy;
        cyc++;
        if (!rst && !prev_rst && prev_valid && !prev_ready &&
            (!drv_pix_valid || drv_pix_data !== prev_data))
            hold_viol++;
        drv_pix_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
        if (drv_pix_valid && drv_pix_ready) begin
            if (got.size() == 0) first_xfer_cyc = cyc;
            got.push_back(drv_pix_data);
            last_xfer_cyc = cyc;
            busy_cnt = busy_tail;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        drv_busy   = (busy_cnt > 0);
        prev_valid = drv_pix_valid;
        prev_ready = drv_pix_ready;
        prev_data  = drv_pix_data;
        prev_rst   = rst;
        if (drv_init_start) begin
            n_init++;
            init_cyc   = cyc;
            init_timer = 0;
        end else if (init_timer < 100000) begin
            init_timer++;
        end
        drv_init_done = init_en && (init_timer >= 10);
        if (drv_win_set_stb) begin
            n_win++;
            win_cyc = cyc;
            wx0 = drv_win_x0; wy0 = drv_win_y0; wx1 = drv_win_x1; wy1 = drv_win_y1;
        end
        if (drv_stream_start) begin
            n_start++;
            start_cyc = cyc;
        end
        if (done_stb) begin
            n_done++;
            done_cyc    = cyc;
            done_busy   = old_busy;
            done_win_ok = (drv_win_x0 == wx0) && (drv_win_y0 == wy0) &&
                          (drv_win_x1 == wx1) && (drv_win_y1 == wy1);
        end
        if (err_stb) begin
            n_errstb++;
            err_cyc = cyc;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Expected raster stream for one rectangle, appended to exp_q
    task automatic model_fill(input int x0, input int y0, input int x1, input int y1,
                              input bit mode, input logic [15:0] c0, input logic [15:0] c1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                int cx, cy;
                cx = (x - x0) / (1 << c_CELL);
                cy = (y - y0) / (1 << c_CELL);
                exp_q.push_back((mode && ((cx + cy) % 2 == 1)) ? c1 : c0);
            end
        end
    endtask

    task automatic send_req(input int x0, input int y0, input int x1, input int y1,
                            input bit mode, input logic [15:0] c0, input logic [15:0] c1,
                            output bit ok);
        int n;
        tick();
        req_x0 = 16'(x0); req_y0 = 16'(y0); req_x1 = 16'(x1); req_y1 = 16'(y1);
        req_mode = mode; req_color0 = c0; req_color1 = c1;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        ok = req_ready;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget, output bit ok);
        int n;
        n = 0;
        while (n_done == prev && n < budget) begin
            tick();
            n++;
        end
        ok = (n_done != prev);
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        int n;
        n = 0;
        while (!(panel_ready && req_ready) && n < budget) begin
            tick();
            n++;
        end
        ok = panel_ready && req_ready;
    endtask

    task automatic test_reset();
        logic [127:0] outs;
        rst = 1'b1;
        repeat (3) tick();
        outs = {req_ready, panel_ready, done_stb, err_stb, drv_init_start, drv_win_set_stb,
                drv_win_x0, drv_win_y0, drv_win_x1, drv_win_y1, drv_stream_start,
                drv_pix_data, drv_pix_valid};
        n_vec++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        n_vec++;
        if (n_init != 0) begin
            n_err++;
            $display("FAIL reset_no_init: %0d init pulses during reset, required 0", n_init);
        end
    endtask

    task automatic test_init();
        int n, rdy_cyc;
        init_en = 1'b1;
        rst = 1'b0;
        n = 0;
        while (!panel_ready && n < 40) begin
            tick();
            n++;
        end
        rdy_cyc = cyc;
        repeat (5) tick();
        n_vec++;
        if (n_init != 1) begin
            n_err++;
            $display("FAIL init_pulses: %0d init pulses, required 1", n_init);
        end
        n_vec++;
        if (rdy_cyc - init_cyc != 11) begin
            n_err++;
            $display("FAIL init_ready_latency: panel_ready %0d cycles after pulse, required 11",
                     rdy_cyc - init_cyc);
        end
        n_vec++;
        if ({panel_ready, req_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL init_ready: panel_ready/req_ready %b, required 11", {panel_ready, req_ready});
        end
        init_en = 1'b0;
        repeat (5) tick();
        n_vec++;
        if (panel_ready !== 1'b1) begin
            n_err++;
            $display("FAIL init_done_drop: panel_ready %b after init_done fell, required 1", panel_ready);
        end
        init_en = 1'b1;
    endtask

    task automatic test_solid();
        bit ok, ok2;
        int w0, s0, d0, bad;
        stall_pct = 40; busy_tail = 3; hold_viol = 0;
        got.delete(); exp_q.delete();
        w0 = n_win; s0 = n_start; d0 = n_done;
        model_fill(0, 0, 3, 1, 1'b0, 16'hF800, 16'h07E0);
        send_req(0, 0, 3, 1, 1'b0, 16'hF800, 16'h07E0, ok);
        n_vec++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL solid_ready_drop: req_ready %b after accept, required 0", req_ready);
        end
        wait_done(d0, 2000, ok2);
        n_vec++;
        if (!ok || !ok2) begin
            n_err++;
            $display("FAIL solid_done: accepted %0d done %0d, required 1 1", ok, ok2);
        end
        n_vec++;
        if (n_win - w0 != 1 || {wx0, wy0, wx1, wy1} !== {16'd0, 16'd0, 16'd3, 16'd1}) begin
            n_err++;
            $display("FAIL solid_window: %0d strobes coords %0d,%0d,%0d,%0d, required 1 strobe 0,0,3,1",
                     n_win - w0, wx0, wy0, wx1, wy1);
        end
        n_vec++;
        if (n_start - s0 != 1 || start_cyc != win_cyc + 1 || first_xfer_cyc <= start_cyc) begin
            n_err++;
            $display("FAIL solid_order: starts %0d win@%0d start@%0d xfer@%0d, required 1 start one cycle after win",
                     n_start - s0, win_cyc, start_cyc, first_xfer_cyc);
        end
        bad = 0;
        foreach (got[i]) if (i < exp_q.size() && got[i] !== exp_q[i]) bad++;
        n_vec++;
        if (got.size() != exp_q.size() || bad != 0) begin
            n_err++;
            $display("FAIL solid_pixels: %0d pixels %0d wrong, required %0d pixels 0 wrong",
                     got.size(), bad, exp_q.size());
        end
        n_vec++;
        if (done_cyc - last_xfer_cyc != 4 || done_busy !== 1'b0 || !done_win_ok || hold_viol != 0) begin
            n_err++;
            $display("FAIL solid_drain: done gap %0d busy %b win_ok %b holds %0d, required 4 0 1 0",
                     done_cyc - last_xfer_cyc, done_busy, done_win_ok, hold_viol);
        end
    endtask

    task automatic test_checker();
        bit ok, ok2;
        int d0, bad;
        stall_pct = 30; busy_tail = 0; hold_viol = 0;
        got.delete(); exp_q.delete();
        d0 = n_done;
        model_fill(0, 0, 15, 15, 1'b1, 16'h0000, 16'hFFFF);
        send_req(0, 0, 15, 15, 1'b1, 16'h0000, 16'hFFFF, ok);
        wait_done(d0, 3000, ok2);
        n_vec++;
        if (!ok || !ok2 || got.size() != 256) begin
            n_err++;
            $display("FAIL checker_count: done %0d transfers %0d, required 1 256", ok2, got.size());
        end
        n_vec++;
        if (got.size() == 256 && {got[8], got[8*16+8], got[9*16+7]} !== {16'hFFFF, 16'h0000, 16'hFFFF}) begin
            n_err++;
            $display("FAIL checker_cells: (8,0)=%h (8,8)=%h (7,9)=%h, required FFFF 0000 FFFF",
                     got[8], got[8*16+8], got[9*16+7]);
        end
        bad = 0;
        foreach (got[i]) if (i < exp_q.size() && got[i] !== exp_q[i]) bad++;
        n_vec++;
        if (bad != 0 || hold_viol != 0 || done_cyc - last_xfer_cyc != 4) begin
            n_err++;
            $display("FAIL checker_stream: %0d wrong holds %0d gap %0d, required 0 0 4",
                     bad, hold_viol, done_cyc - last_xfer_cyc);
        end
    endtask

    task automatic test_reject();
        bit ok;
        int w0, s0, e0, g0;
        int bx0[4] = '{5, 0, 0, 0};
        int by0[4] = '{0, 0, 4, 0};
        int bx1[4] = '{4, 240, 3, 0};
        int by1[4] = '{0, 0, 3, 320};
        for (int k = 0; k < 4; k++) begin
            w0 = n_win; s0 = n_start; e0 = n_errstb; g0 = got.size();
            send_req(bx0[k], by0[k], bx1[k], by1[k], 1'b0, 16'h1111, 16'h2222, ok);
            repeat (4) tick();
            n_vec++;
            if (!ok || n_errstb - e0 != 1 || n_win != w0 || n_start != s0 ||
                got.size() != g0 || req_ready !== 1'b1) begin
                n_err++;
                $display("FAIL reject_%0d: err %0d win %0d start %0d px %0d ready %b, required 1 0 0 0 1",
                         k, n_errstb - e0, n_win - w0, n_start - s0, got.size() - g0, req_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok, ok2, ok3, ok4;
        int w0, d0, bad;
        stall_pct = 0; busy_tail = 2; hold_viol = 0;
        got.delete(); exp_q.delete();
        w0 = n_win; d0 = n_done;
        model_fill(239, 319, 239, 319, 1'b1, 16'h1234, 16'hABCD);
        model_fill(0, 0, 9, 0, 1'b1, 16'h1234, 16'hABCD);
        send_req(239, 319, 239, 319, 1'b1, 16'h1234, 16'hABCD, ok);
        wait_done(d0, 500, ok2);
        n_vec++;
        if (got.size() != 1 || done_cyc - last_xfer_cyc != 4) begin
            n_err++;
            $display("FAIL b2b_single: %0d pixels gap %0d, required 1 pixel gap 4",
                     got.size(), done_cyc - last_xfer_cyc);
        end
        send_req(0, 0, 9, 0, 1'b1, 16'h1234, 16'hABCD, ok3);
        wait_done(d0 + 1, 500, ok4);
        bad = 0;
        foreach (got[i]) if (i < exp_q.size() && got[i] !== exp_q[i]) bad++;
        n_vec++;
        if (!(ok && ok2 && ok3 && ok4) || n_win - w0 != 2 || got.size() != 11 || bad != 0 || hold_viol != 0) begin
            n_err++;
            $display("FAIL b2b_pair: wins %0d pixels %0d wrong %0d holds %0d, required 2 11 0 0",
                     n_win - w0, got.size(), bad, hold_viol);
        end
    endtask

    task automatic test_random();
        bit ok, ok2;
        int w, h, x0, y0, d0, bad, exp_gap;
        logic [15:0] c0, c1;
        bit mode;
        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(1, 20);
            h = $urandom_range(1, 12);
            x0 = (i == 0) ? c_X_RES - w : $urandom_range(0, c_X_RES - w);
            y0 = (i == 0) ? c_Y_RES - h : $urandom_range(0, c_Y_RES - h);
            mode = 1'($urandom_range(0, 1));
            c0 = 16'($urandom);
            c1 = 16'($urandom);
            stall_pct = $urandom_range(0, 60);
            busy_tail = $urandom_range(0, 6);
            exp_gap = ((busy_tail > 3) ? busy_tail : 3) + 1;
            hold_viol = 0;
            got.delete(); exp_q.delete();
            d0 = n_done;
            model_fill(x0, y0, x0 + w - 1, y0 + h - 1, mode, c0, c1);
            send_req(x0, y0, x0 + w - 1, y0 + h - 1, mode, c0, c1, ok);
            wait_done(d0, 3000, ok2);
            bad = 0;
            foreach (got[j]) if (j < exp_q.size() && got[j] !== exp_q[j]) bad++;
            n_vec++;
            if (!ok || !ok2 || got.size() != exp_q.size() || bad != 0 || hold_viol != 0 ||
                done_cyc - last_xfer_cyc != exp_gap || done_busy !== 1'b0) begin
                n_err++;
                $display("FAIL random_%0d: px %0d/%0d wrong %0d holds %0d gap %0d/%0d busy %b",
                         i, got.size(), exp_q.size(), bad, hold_viol,
                         done_cyc - last_xfer_cyc, exp_gap, done_busy);
            end
        end
    endtask

    task automatic test_timeout();
        int i0, e0, n, c1;
        bit ok;
        init_en = 1'b0;
        tick();
        rst = 1'b1;
        repeat (2) tick();
        i0 = n_init; e0 = n_errstb;
        rst = 1'b0;
        n = 0;
        while (n_init == i0 && n < 10) begin tick(); n++; end
        c1 = init_cyc;
        n = 0;
        while (n_errstb == e0 && n < 300) begin tick(); n++; end
        n_vec++;
        if (n_errstb - e0 != 1 || err_cyc - c1 < 99 || err_cyc - c1 > 101) begin
            n_err++;
            $display("FAIL timeout_err: %0d err pulses gap %0d, required 1 pulse gap 99..101",
                     n_errstb - e0, err_cyc - c1);
        end
        n = 0;
        while (n_init < i0 + 2 && n < 10) begin tick(); n++; end
        n_vec++;
        if (n_init - i0 != 2 || init_cyc - err_cyc > 2 || panel_ready !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_rekick: %0d pulses rekick gap %0d ready %b, required 2 <=2 0",
                     n_init - i0, init_cyc - err_cyc, panel_ready);
        end
        init_en = 1'b1;
        wait_ready(300, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL timeout_recover: panel_ready %b req_ready %b, required 1 1", panel_ready, req_ready);
        end
    endtask

    task automatic test_mid_reset();
        bit ok, ok2;
        int n, i0, d0, bad;
        logic [127:0] outs;
        stall_pct = 50; busy_tail = 0;
        got.delete();
        send_req(0, 0, 99, 9, 1'b1, 16'h0F0F, 16'hF0F0, ok);
        n = 0;
        while (got.size() < 3 && n < 500) begin tick(); n++; end
        rst = 1'b1;
        i0 = n_init;
        tick();
        outs = {req_ready, panel_ready, done_stb, err_stb, drv_init_start, drv_win_set_stb,
                drv_win_x0, drv_win_y0, drv_win_x1, drv_win_y1, drv_stream_start,
                drv_pix_data, drv_pix_valid};
        n_vec++;
        if (!ok || outs !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got %h, required 0", outs);
        end
        rst = 1'b0;
        n = 0;
        while (n_init == i0 && n < 5) begin tick(); n++; end
        n_vec++;
        if (n_init - i0 != 1) begin
            n_err++;
            $display("FAIL midreset_init: %0d init pulses after reset, required 1", n_init - i0);
        end
        wait_ready(100, ok);
        stall_pct = 20; hold_viol = 0;
        got.delete(); exp_q.delete();
        d0 = n_done;
        model_fill(100, 200, 104, 202, 1'b0, 16'h07E0, 16'h001F);
        send_req(100, 200, 104, 202, 1'b0, 16'h07E0, 16'h001F, ok2);
        wait_done(d0, 1000, ok);
        bad = 0;
        foreach (got[i]) if (i < exp_q.size() && got[i] !== exp_q[i]) bad++;
        n_vec++;
        if (!ok || !ok2 || got.size() != 15 || bad != 0) begin
            n_err++;
            $display("FAIL midreset_refill: done %0d px %0d wrong %0d, required 1 15 0", ok, got.size(), bad);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_solid();
        test_checker();
        test_reject();
        test_back_to_back();
        test_random();
        test_timeout();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
